// File: rtl/toggle_event_decoder.sv
// Purpose : turn level changes on a toggle line from another clock domain into
//           single-cycle event pulses and a drainable, saturating event queue.
// Latency : a tog_in change sampled on edge k pulses evt_pulse after edge k+SYNC_STAGES.
// Backpr. : events queue in 'pending' until ev_ready drains them. At saturation,
//           new events are counted in 'total' and flagged in 'ovf'; they are not queued.
//
// Ports:
//   clk, rst      single rising-edge clock; asynchronous active-high reset
//   tog_in        asynchronous toggle level from the remote encoder
//   ev_ready      consumer takes one pending event when ev_valid is high
//   clr_ovf       synchronous clear of the sticky overflow flag
//   evt_pulse     one-cycle pulse per detected tog_in transition
//   ev_valid      registered (pending != 0); no combinational path from ev_ready
//   pending       queued, unconsumed events (saturates at 2^CNT_W-1)
//   total         events detected since reset, wrapping modulo 2^TOT_W
//   ovf           sticky: an event arrived while pending was saturated
//   armed         decoder has captured a reference level and is tracking edges
//
// Reset is asserted asynchronously. Deassertion is expected to be aligned to
// clk by the surrounding reset logic. SYNC_STAGES must be in the range 2..4.

module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TOT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             ev_ready,
  input  logic             clr_ovf,
  output logic             evt_pulse,
  output logic             ev_valid,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total,
  output logic             ovf,
  output logic             armed
);

  // The arm counter must be able to hold SYNC_STAGES+1.
  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   ref_lvl;
  logic [ARM_W-1:0]       arm_cnt;

  logic                   det;
  logic                   inc;
  logic                   dec;
  logic [CNT_W-1:0]       pending_nxt;
  logic                   ovf_set;
  logic                   ovf_nxt;

  // ---------------------------------------------------------------------------
  // Synchroniser: s[0] samples tog_in, and each later stage copies the previous one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Arming. After reset, the synchroniser needs SYNC_STAGES edges to fill with
  // real tog_in samples. The reference level keeps tracking sync_out until then.
  // As a result, a nonzero tog_in level present at reset release becomes the
  // baseline and is never reported as an event. Arming occurs on the edge where
  // the counter would reach SYNC_STAGES+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lvl <= 1'b0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      ref_lvl <= sync_out;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
        if (arm_cnt == ARM_LAST) begin
          armed <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transition detect and queue control
  // ---------------------------------------------------------------------------
  assign det = sync_out ^ ref_lvl;
  assign inc = det & armed;
  // ev_valid is registered, so the dequeue term never depends combinationally
  // on pending, and ev_ready while empty cannot underflow.
  assign dec = ev_valid & ev_ready;

  always_comb begin
    pending_nxt = pending;
    ovf_set     = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (pending == CNT_MAX) begin
          ovf_set = 1'b1;
        end else begin
          pending_nxt = pending + CNT_W'(1);
        end
      end
      2'b01: pending_nxt = pending - CNT_W'(1);
      // A simultaneous enqueue and dequeue is a net no-op. When saturated,
      // the arriving event takes the freed slot, so no overflow occurs.
      default: pending_nxt = pending;
    endcase
  end

  // A new overflow takes priority over clr_ovf on the same edge.
  assign ovf_nxt = ovf_set | (ovf & ~clr_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_pulse <= 1'b0;
      pending   <= '0;
      ev_valid  <= 1'b0;
      total     <= '0;
      ovf       <= 1'b0;
    end else begin
      evt_pulse <= inc;
      pending   <= pending_nxt;
      ev_valid  <= (pending_nxt != '0);
      total     <= total + TOT_W'(inc);
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
module tb_toggle_event_decoder;

  logic        clk;
  logic        rst;
  logic        tog_in;
  logic        ev_ready;
  logic        clr_ovf;
  logic        evt_pulse;
  logic        ev_valid;
  logic [3:0]  pending;
  logic [15:0] total;
  logic        ovf;
  logic        armed;

  int n_chk = 0;
  int n_bad = 0;

  toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .ev_ready  (ev_ready),
    .clr_ovf   (clr_ovf),
    .evt_pulse (evt_pulse),
    .ev_valid  (ev_valid),
    .pending   (pending),
    .total     (total),
    .ovf       (ovf),
    .armed     (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tog;
    logic rdy;
    logic clr;
    logic pulse;
    logic valid;
    int   pend;
    int   tot;
    logic ovf;
    logic armed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic r, input logic c,
                     input logic p, input logic v, input int pe, input int to,
                     input logic o, input logic a);
    vec_t x;
    x.tog = t; x.rdy = r; x.clr = c; x.pulse = p; x.valid = v;
    x.pend = pe; x.tot = to; x.ovf = o; x.armed = a;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge. Outputs are sampled 1 ns after the edge, and inputs set
  // afterwards take effect on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flip tog_in and wait long enough for the event to be enqueued (edge +2).
  task automatic toggle_n();
    tog_in = ~tog_in;
    repeat (4) step();
  endtask

  initial begin
    rst      = 1'b1;
    tog_in   = 1'b1;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) step();
    check("rst.pulse",   32'(evt_pulse), 0);
    check("rst.valid",   32'(ev_valid),  0);
    check("rst.pending", 32'(pending),   0);
    check("rst.total",   32'(total),     0);
    check("rst.ovf",     32'(ovf),       0);
    check("rst.armed",   32'(armed),     0);

    // ---------------- table: arming, 5 toggles, drain ----------------
    //   tog rdy clr | pulse valid pend tot ovf armed
    add(1,0,0, 0,0,0,0,0,0);  // 0: edge 1 after release
    add(1,0,0, 0,0,0,0,0,0);  // 1
    add(1,0,0, 0,0,0,0,0,1);  // 2: armed on 3rd edge, tog=1 gives no event
    add(1,0,0, 0,0,0,0,0,1);  // 3
    add(0,0,0, 0,0,0,0,0,1);  // 4: toggle sampled
    add(0,0,0, 0,0,0,0,0,1);  // 5
    add(0,0,0, 1,1,1,1,0,1);  // 6: pulse 2 edges later
    add(0,0,0, 0,1,1,1,0,1);  // 7
    add(1,0,0, 0,1,1,1,0,1);  // 8
    add(1,0,0, 0,1,1,1,0,1);  // 9
    add(1,0,0, 1,1,2,2,0,1);  // 10
    add(1,0,0, 0,1,2,2,0,1);  // 11
    add(0,0,0, 0,1,2,2,0,1);  // 12
    add(0,0,0, 0,1,2,2,0,1);  // 13
    add(0,0,0, 1,1,3,3,0,1);  // 14
    add(0,0,0, 0,1,3,3,0,1);  // 15
    add(1,0,0, 0,1,3,3,0,1);  // 16
    add(1,0,0, 0,1,3,3,0,1);  // 17
    add(1,0,0, 1,1,4,4,0,1);  // 18
    add(1,0,0, 0,1,4,4,0,1);  // 19
    add(0,0,0, 0,1,4,4,0,1);  // 20
    add(0,0,0, 0,1,4,4,0,1);  // 21
    add(0,0,0, 1,1,5,5,0,1);  // 22
    add(0,0,0, 0,1,5,5,0,1);  // 23
    add(0,1,0, 0,1,4,5,0,1);  // 24: drain
    add(0,1,0, 0,1,3,5,0,1);  // 25
    add(0,1,0, 0,1,2,5,0,1);  // 26
    add(0,1,0, 0,1,1,5,0,1);  // 27
    add(0,1,0, 0,0,0,5,0,1);  // 28
    add(0,1,0, 0,0,0,5,0,1);  // 29: ready while empty

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      tog_in   = vecs[i].tog;
      ev_ready = vecs[i].rdy;
      clr_ovf  = vecs[i].clr;
      step();
      check($sformatf("v%0d.pulse", i),   32'(evt_pulse), 32'(vecs[i].pulse));
      check($sformatf("v%0d.valid", i),   32'(ev_valid),  32'(vecs[i].valid));
      check($sformatf("v%0d.pending", i), 32'(pending),   32'(vecs[i].pend));
      check($sformatf("v%0d.total", i),   32'(total),     32'(vecs[i].tot));
      check($sformatf("v%0d.ovf", i),     32'(ovf),       32'(vecs[i].ovf));
      check($sformatf("v%0d.armed", i),   32'(armed),     32'(vecs[i].armed));
    end
    ev_ready = 1'b0;

    // ---------------- enqueue coinciding with dequeue ----------------
    repeat (3) toggle_n();
    check("coin.pre_pending", 32'(pending), 3);
    check("coin.pre_total",   32'(total),   8);
    tog_in = ~tog_in;
    step();
    step();
    ev_ready = 1'b1;
    step();
    check("coin.pulse",   32'(evt_pulse), 1);
    check("coin.pending", 32'(pending),   3);
    check("coin.total",   32'(total),     9);
    ev_ready = 1'b0;
    step();
    check("coin.after_pulse",   32'(evt_pulse), 0);
    check("coin.after_pending", 32'(pending),   3);

    // ---------------- saturation and overflow ----------------
    ev_ready = 1'b1;
    repeat (3) step();
    ev_ready = 1'b0;
    check("sat.drained", 32'(pending),  0);
    check("sat.invalid", 32'(ev_valid), 0);
    for (int i = 1; i <= 17; i++) begin
      toggle_n();
      check($sformatf("sat%0d.pending", i), 32'(pending), (i > 15) ? 15 : i);
      check($sformatf("sat%0d.ovf", i),     32'(ovf),     (i >= 16) ? 1 : 0);
      check($sformatf("sat%0d.total", i),   32'(total),   32'(9 + i));
    end
    check("sat.valid", 32'(ev_valid), 1);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr.ovf",     32'(ovf),     0);
    check("clr.pending", 32'(pending), 15);

    // A clear that coincides with a new overflow leaves ovf set.
    tog_in = ~tog_in;
    step();
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("setwin.ovf",     32'(ovf),     1);
    check("setwin.total",   32'(total),   27);
    check("setwin.pending", 32'(pending), 15);
    step();
    check("setwin.sticky", 32'(ovf), 1);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr2.ovf", 32'(ovf), 0);

    // Saturated enqueue plus dequeue: pending stays the same and no overflow is set.
    tog_in = ~tog_in;
    step();
    step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("satcoin.pending", 32'(pending), 15);
    check("satcoin.ovf",     32'(ovf),     0);
    check("satcoin.total",   32'(total),   28);

    // ---------------- reset mid-operation ----------------
    ev_ready = 1'b1;
    repeat (8) step();
    ev_ready = 1'b0;
    check("mid.pending", 32'(pending), 7);
    tog_in = ~tog_in;
    step();  // toggle now sits in the synchroniser
    rst = 1'b1;
    #1;
    check("mid.rst_pulse",   32'(evt_pulse), 0);
    check("mid.rst_valid",   32'(ev_valid),  0);
    check("mid.rst_pending", 32'(pending),   0);
    check("mid.rst_total",   32'(total),     0);
    check("mid.rst_ovf",     32'(ovf),       0);
    check("mid.rst_armed",   32'(armed),     0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rearm.e1", 32'(armed), 0);
    step();
    check("rearm.e2", 32'(armed), 0);
    step();
    check("rearm.e3", 32'(armed), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rearm.quiet%0d", i), 32'(evt_pulse), 0);
    end
    check("rearm.pending", 32'(pending), 0);
    check("rearm.total",   32'(total),   0);
    toggle_n();
    check("rearm.new_pending", 32'(pending), 1);
    check("rearm.new_total",   32'(total),   1);
    check("rearm.new_ovf",     32'(ovf),     0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
